// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store initiator for a single-cycle word RAM. Define
//            LSU_RMW_EN to make SB/SH read-modify-write on any lane.
// Revision : 1.0
// ============================================================================
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] ram_addr,
  output logic [1:0]  write_ram_flag,
  output logic [2:0]  load_ram_flag,
  output logic [31:0] write_ram_data,
  input  logic [31:0] ram_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_data_q, ram_addr_q, wr_data_q;
  logic [1:0]  wflag_q;
  logic [2:0]  lflag_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
`ifdef LSU_RMW_EN
  logic [15:0] wdata_q;
  logic        is_store_q;
`endif

  logic        err_d;
  logic        to_read_d;
  logic [1:0]  wflag_d;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

`ifdef LSU_RMW_EN
  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] lane,
                                             input logic is_byte, input logic [15:0] d);
    merge_lane = w;
    if (is_byte) merge_lane[{lane, 3'b000} +: 8] = d[7:0];
    else         merge_lane[{lane[1], 4'b0000} +: 16] = d;
  endfunction
`endif

  // Request decode: alignment/legality, first state and native write encoding.
  always_comb begin
    err_d = 1'b0;
    case (req_funct3[1:0])
      2'b00:   err_d = 1'b0;
      2'b01:   err_d = req_addr[0];
      2'b10:   err_d = (req_addr[1:0] != 2'b00);
      default: err_d = 1'b1;
    endcase
    if (req_funct3[2] && (req_is_store || req_funct3[1])) err_d = 1'b1;
`ifdef LSU_RMW_EN
    to_read_d = !req_is_store || (req_funct3[1:0] != 2'b10);
`else
    if (req_is_store && (req_addr[1:0] != 2'b00)) err_d = 1'b1;
    to_read_d = !req_is_store;
`endif
    case (req_funct3[1:0])
      2'b00:   wflag_d = 2'b11;
      2'b01:   wflag_d = 2'b10;
      default: wflag_d = 2'b01;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
      ram_addr_q  <= 32'd0;
      wr_data_q   <= 32'd0;
      wflag_q     <= 2'b00;
      lflag_q     <= 3'b000;
      lane_q      <= 2'b00;
      funct3_q    <= 3'b000;
`ifdef LSU_RMW_EN
      wdata_q     <= 16'd0;
      is_store_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            lane_q      <= req_addr[1:0];
            funct3_q    <= req_funct3;
`ifdef LSU_RMW_EN
            wdata_q     <= req_wdata[15:0];
            is_store_q  <= req_is_store;
`endif
            if (err_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'd0;
              state_q     <= S_RESP;
            end else if (to_read_d) begin
              ram_addr_q <= {2'b00, req_addr[31:2]};
              lflag_q    <= 3'b001;
              state_q    <= S_READ;
            end else begin
              ram_addr_q <= {2'b00, req_addr[31:2]};
              wr_data_q  <= req_wdata;
              wflag_q    <= wflag_d;
              state_q    <= S_WRITE;
            end
          end
        end
        S_READ: begin
          lflag_q <= 3'b000;
`ifdef LSU_RMW_EN
          if (is_store_q) begin
            wr_data_q <= merge_lane(ram_out, lane_q, (funct3_q[1:0] == 2'b00), wdata_q);
            wflag_q   <= 2'b01;
            state_q   <= S_WRITE;
          end else
`endif
          begin
            ram_addr_q  <= 32'd0;
            rsp_data_q  <= load_ext(ram_out, lane_q, funct3_q);
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_WRITE: begin
          wflag_q     <= 2'b00;
          ram_addr_q  <= 32'd0;
          wr_data_q   <= 32'd0;
          rsp_data_q  <= 32'd0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign ram_addr       = ram_addr_q;
  assign write_ram_flag = wflag_q;
  assign load_ram_flag  = lflag_q;
  assign write_ram_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed self-checking bench for lsu_ctrl with a word RAM model.
// Revision : 1.0
// ============================================================================
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data, ram_addr, write_ram_data, ram_out;
  logic [1:0]  write_ram_flag;
  logic [2:0]  load_ram_flag;

  int n_cmp  = 0;
  int n_fail = 0;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .write_ram_flag(write_ram_flag), .load_ram_flag(load_ram_flag),
    .write_ram_data(write_ram_data), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Word RAM: combinational read, write on the rising edge per flag encoding.
  logic [31:0] mem [0:15];
  assign ram_out = mem[ram_addr[3:0]];
  always @(posedge clk) begin
    case (write_ram_flag)
      2'b01:   mem[ram_addr[3:0]]       <= write_ram_data;
      2'b10:   mem[ram_addr[3:0]][15:0] <= write_ram_data[15:0];
      2'b11:   mem[ram_addr[3:0]][7:0]  <= write_ram_data[7:0];
      default: ;
    endcase
  end

  int          ram_cycles = 0;
  logic [1:0]  last_wflag = 2'b00;
  logic [31:0] last_raddr = 32'd0;
  always @(negedge clk) begin
    if (write_ram_flag != 2'b00 || load_ram_flag != 3'b000) begin
      ram_cycles++;
      last_raddr = ram_addr;
      if (write_ram_flag != 2'b00) last_wflag = write_ram_flag;
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] d,
                        output logic e, output int touched);
    int k;
    int base;
    lat = -1; d = 'x; e = 1'bx; touched = 0; k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    base = ram_cycles;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; d = rsp_data; e = rsp_err;
        break;
      end
    end
    touched = ram_cycles - base;
    if (lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_wait: rsp_valid never seen, required within 8 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid, rsp_err} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ctrl: ready/valid/err=%b required 000", {req_ready, rsp_valid, rsp_err}); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_fail++;
      $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
    n_cmp++; if ({ram_addr, write_ram_data} !== 64'd0) begin n_fail++;
      $display("FAIL reset_ram_bus: addr %h wdata %h required 0", ram_addr, write_ram_data); end
    n_cmp++; if ({write_ram_flag, load_ram_flag} !== 5'd0) begin n_fail++;
      $display("FAIL reset_flags: w %b l %b required 0", write_ram_flag, load_ram_flag); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_load_word;
    int lat, t; logic [31:0] d; logic e;
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, d, e, t);
    n_cmp++; if (d !== 32'hF2345678) begin n_fail++;
      $display("FAIL lw_data: got %h required F2345678", d); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b required 0", e); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d required 2", lat); end
    n_cmp++; if (last_raddr !== 32'd4) begin n_fail++;
      $display("FAIL lw_ram_addr: got %h required 4", last_raddr); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exs [4] = '{32'hFFFFFFF2, 32'h000000F2, 32'hFFFFF234, 32'h00005678};
    int lat, t; logic [31:0] d; logic e;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], as[i], 32'd0, lat, d, e, t);
      n_cmp++; if (d !== exs[i] || e !== 1'b0 || lat !== 2) begin n_fail++;
        $display("FAIL load_ext_%0d: data %h err %b lat %0d required %h 0 2", i, d, e, lat, exs[i]); end
    end
  endtask

  task automatic test_store;
    int lat, t; logic [31:0] d; logic e;
    mem[1] = 32'h22222222;
`ifdef LSU_RMW_EN
    do_req(1'b1, 3'b000, 32'h05, 32'h000000AB, lat, d, e, t);
    n_cmp++; if (mem[1] !== 32'h2222AB22) begin n_fail++;
      $display("FAIL rmw_sb_mem: got %h required 2222AB22", mem[1]); end
    n_cmp++; if (lat !== 3 || e !== 1'b0) begin n_fail++;
      $display("FAIL rmw_sb_rsp: lat %0d err %b required 3 0", lat, e); end
    n_cmp++; if (last_wflag !== 2'b01) begin n_fail++;
      $display("FAIL rmw_sb_flag: got %b required 01", last_wflag); end
    do_req(1'b1, 3'b001, 32'h06, 32'h0000BEEF, lat, d, e, t);
    n_cmp++; if (mem[1] !== 32'hBEEFAB22) begin n_fail++;
      $display("FAIL rmw_sh_mem: got %h required BEEFAB22", mem[1]); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rmw_sh_latency: got %0d required 3", lat); end
`else
    do_req(1'b1, 3'b000, 32'h04, 32'hFFFFFF5A, lat, d, e, t);
    n_cmp++; if (mem[1] !== 32'h2222225A) begin n_fail++;
      $display("FAIL sb_mem: got %h required 2222225A", mem[1]); end
    n_cmp++; if (last_wflag !== 2'b11 || lat !== 2) begin n_fail++;
      $display("FAIL sb_flag_lat: flag %b lat %0d required 11 2", last_wflag, lat); end
    do_req(1'b1, 3'b000, 32'h05, 32'h000000AB, lat, d, e, t);
    n_cmp++; if (e !== 1'b1 || lat !== 1 || t !== 0) begin n_fail++;
      $display("FAIL sb_lane1_err: err %b lat %0d ramcyc %0d required 1 1 0", e, lat, t); end
    n_cmp++; if (mem[1] !== 32'h2222225A) begin n_fail++;
      $display("FAIL sb_lane1_mem: got %h required 2222225A", mem[1]); end
`endif
    do_req(1'b1, 3'b010, 32'h0C, 32'h12345678, lat, d, e, t);
    n_cmp++; if (mem[3] !== 32'h12345678 || last_wflag !== 2'b01) begin n_fail++;
      $display("FAIL sw_mem: got %h flag %b required 12345678 01", mem[3], last_wflag); end
    n_cmp++; if (lat !== 2 || d !== 32'd0 || e !== 1'b0) begin n_fail++;
      $display("FAIL sw_rsp: lat %0d data %h err %b required 2 0 0", lat, d, e); end
  endtask

  task automatic test_errors;
    logic        sts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b110};
    logic [31:0] as  [4] = '{32'h02, 32'h01, 32'h00, 32'h00};
    int lat, t; logic [31:0] d; logic e;
    for (int i = 0; i < 4; i++) begin
      do_req(sts[i], f3s[i], as[i], 32'hDEADBEEF, lat, d, e, t);
      n_cmp++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++;
        $display("FAIL err_%0d_rsp: err %b data %h required 1 0", i, e, d); end
      n_cmp++; if (lat !== 1 || t !== 0) begin n_fail++;
        $display("FAIL err_%0d_timing: lat %0d ramcyc %0d required 1 0", i, lat, t); end
    end
  endtask

  task automatic test_handshake;
    int lat, t; logic [31:0] d; logic e;
    @(posedge clk); #1 rsp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, d, e, t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hF2345678) begin n_fail++;
        $display("FAIL hold_%0d: valid %b data %h required 1 F2345678", i, rsp_valid, rsp_data); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL hold_release: valid %b ready %b required 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    int v1 = -1, v2 = -1, nv = 0, k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        nv++;
        if (v1 < 0) v1 = c; else if (v2 < 0) v2 = c;
      end
    end
    req_valid = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    n_cmp++; if (nv !== 2 || v1 !== 2 || v2 !== 5) begin n_fail++;
      $display("FAIL back_to_back: count %0d at %0d,%0d required 2 at 2,5", nv, v1, v2); end
  endtask

  task automatic test_reset_mid_write;
    int k = 0;
    mem[2] = 32'h33333333;
    @(negedge clk);
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_cmp++; if (write_ram_flag !== 2'b01) begin n_fail++;
      $display("FAIL mid_write_state: flag %b required 01", write_ram_flag); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({write_ram_flag, load_ram_flag, ram_addr, write_ram_data} !== 69'd0) begin n_fail++;
      $display("FAIL mid_reset_ram: flags %b %b addr %h data %h required 0",
               write_ram_flag, load_ram_flag, ram_addr, write_ram_data); end
    n_cmp++; if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_data !== 32'd0) begin n_fail++;
      $display("FAIL mid_reset_ctrl: rdy %b vld %b err %b data %h required 0",
               req_ready, rsp_valid, rsp_err, rsp_data); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (mem[2] !== 32'h33333333) begin n_fail++;
      $display("FAIL mid_reset_mem: got %h required 33333333", mem[2]); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset_recover: rdy %b vld %b required 1 0", req_ready, rsp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[4] = 32'hF2345678;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_errors();
    test_handshake();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
